// File: rtl/rgb2gray_frame_writer.sv
// Converts a frame of RGB pixels to 8-bit-per-channel luma and writes each
// gray sample to a frame buffer, with end-of-frame handshake and status flags.
module rgb2gray_frame_writer #(
  parameter int DATA_WIDTH   = 8,
  parameter int TOTAL_PIXELS = 42240,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3*DATA_WIDTH-1:0] rgb_data,
  input  logic                    pixel_done,
  input  logic                    frame_done,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic                    frame_ready,
  output logic                    busy,
  output logic                    short_frame,
  output logic                    err_overrun
);

  localparam int PROD_W = DATA_WIDTH + 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_PIXELS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_FLUSH, ST_DONE} state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  flush_cnt;
  logic                  short_cand;
  logic                  accept;
  logic                  short_ld;
  logic                  short_val;
  logic                  err_set;

  logic [DATA_WIDTH-1:0] r_in, g_in, b_in;
  logic [PROD_W-1:0]     prod_r_p1, prod_g_p1, prod_b_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic                  vld_p1;

  // Weights sum to 256, so the result always fits without saturation.
  function automatic logic [DATA_WIDTH-1:0] gray_from_products(
    input logic [PROD_W-1:0] pr,
    input logic [PROD_W-1:0] pg,
    input logic [PROD_W-1:0] pb
  );
    logic [PROD_W-1:0] sum;
    sum = pr + pg + pb;
    return DATA_WIDTH'(sum >> 8);
  endfunction

  assign r_in = rgb_data[3*DATA_WIDTH-1:2*DATA_WIDTH];
  assign g_in = rgb_data[2*DATA_WIDTH-1:DATA_WIDTH];
  assign b_in = rgb_data[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (frame_done) state_nx = ST_FLUSH;
                else if (pixel_done) state_nx = ST_RECV;
      ST_RECV:  if (frame_done) state_nx = ST_FLUSH;
      ST_FLUSH: if (flush_cnt) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // frame_done always wins over a coincident pixel_done, which is then an error.
  always_comb begin
    busy        = (state != ST_IDLE);
    frame_ready = (state == ST_DONE);
    accept      = 1'b0;
    short_ld    = 1'b0;
    short_val   = 1'b0;
    err_set     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (frame_done) begin
          short_ld  = 1'b1;
          short_val = 1'b1;
          err_set   = pixel_done;
        end else if (pixel_done) begin
          accept = 1'b1;
        end
      end
      ST_RECV: begin
        if (frame_done) begin
          short_ld  = 1'b1;
          err_set   = pixel_done;
          accept    = (wr_addr == LAST_ADDR);
          short_val = (wr_addr != LAST_ADDR);
        end else if (pixel_done) begin
          accept  = (wr_addr < LAST_ADDR);
          err_set = (wr_addr >= LAST_ADDR);
        end
      end
      default: err_set = pixel_done | frame_done;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_addr     <= '0;
      flush_cnt   <= 1'b0;
      short_cand  <= 1'b0;
      short_frame <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (state == ST_DONE) wr_addr <= '0;
      else if (accept)      wr_addr <= wr_addr + ADDR_WIDTH'(1);
      flush_cnt <= (state == ST_FLUSH) ? ~flush_cnt : 1'b0;
      if (short_ld)         short_cand  <= short_val;
      if (state == ST_DONE) short_frame <= short_cand;
      if (err_set)          err_overrun <= 1'b1;
    end
  end

  // ---- stage 1: products and write address ----
  always_ff @(posedge clk) begin
    if (accept) begin
      prod_r_p1 <= PROD_W'(r_in) * PROD_W'(77);
      prod_g_p1 <= PROD_W'(g_in) * PROD_W'(150);
      prod_b_p1 <= PROD_W'(b_in) * PROD_W'(29);
      addr_p1   <= wr_addr;
    end
  end

  // ---- stage 2: sum onto the memory write port ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      vld_p1 <= accept;
      mem_we <= vld_p1;
      if (vld_p1) begin
        mem_addr  <= addr_p1;
        mem_wdata <= gray_from_products(prod_r_p1, prod_g_p1, prod_b_p1);
      end
    end
  end

endmodule

// File: tb/tb_rgb2gray_frame_writer.sv
// Randomized and directed bench for rgb2gray_frame_writer with a cycle-indexed
// reference model of expected writes, frame_ready pulses and status flags.
module tb_rgb2gray_frame_writer;

  localparam int DW   = 8;
  localparam int TP   = 4;
  localparam int AW   = 16;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic [3*DW-1:0] rgb_data;
  logic          pixel_done;
  logic          frame_done;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          frame_ready;
  logic          busy;
  logic          short_frame;
  logic          err_overrun;

  rgb2gray_frame_writer #(.DATA_WIDTH(DW), .TOTAL_PIXELS(TP), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .rgb_data(rgb_data),
    .pixel_done(pixel_done), .frame_done(frame_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .frame_ready(frame_ready), .busy(busy),
    .short_frame(short_frame), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;

  bit exp_we    [MAXC];
  int exp_addr  [MAXC];
  int exp_data  [MAXC];
  bit exp_fr    [MAXC];
  bit exp_err   [MAXC];
  bit exp_short [MAXC];
  bit exp_busy  [MAXC];
  bit rst_chk   [MAXC];

  bit model_valid = 0;
  int count       = 0;
  bit err         = 0;
  bit short_now   = 0;
  bit pend_val    = 0;
  int pend_cyc    = -1;
  int busy_until  = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, expv, k);
    end
  endtask

  function automatic int gray_ref(input logic [23:0] c);
    return (77 * int'(c[23:16]) + 150 * int'(c[15:8]) + 29 * int'(c[7:0])) / 256;
  endfunction

  // Frame-level view: pixels in the current frame, and a 3-cycle blackout
  // after each frame_done during which every strobe is an overrun.
  task automatic model(input bit p, input bit f, input logic [23:0] rgb, input bit r);
    int nk;
    nk = k + 1;
    if (r) begin
      for (int i = nk; i < MAXC; i++) begin
        exp_we[i] = 0;
        exp_fr[i] = 0;
      end
      count = 0; err = 0; short_now = 0; pend_cyc = -1; busy_until = -1;
      exp_err[nk] = 0; exp_short[nk] = 0; exp_busy[nk] = 0; rst_chk[nk] = 1;
      model_valid = 1;
      return;
    end
    if (k <= busy_until) begin
      if (p || f) err = 1;
    end else if (f) begin
      if (p) err = 1;
      if (count == TP - 1) begin
        exp_we[k+2] = 1; exp_addr[k+2] = count; exp_data[k+2] = gray_ref(rgb);
        pend_val = 0;
      end else begin
        pend_val = 1;
      end
      pend_cyc = k + 4;
      count = 0;
      busy_until = k + 3;
      exp_fr[k+3] = 1;
    end else if (p) begin
      if (count < TP - 1) begin
        exp_we[k+2] = 1; exp_addr[k+2] = count; exp_data[k+2] = gray_ref(rgb);
        count++;
      end else begin
        err = 1;
      end
    end
    if (pend_cyc == nk) short_now = pend_val;
    exp_err[nk]   = err;
    exp_short[nk] = short_now;
    exp_busy[nk]  = (count > 0) || (nk <= busy_until);
    rst_chk[nk]   = 0;
  endtask

  task automatic step(input bit p, input bit f, input logic [23:0] rgb, input bit r);
    @(negedge clk);
    if (model_valid) begin
      check("mem_we", 32'(mem_we), 32'(exp_we[k]));
      if (exp_we[k]) begin
        check("mem_addr", 32'(mem_addr), 32'(exp_addr[k]));
        check("mem_wdata", 32'(mem_wdata), 32'(exp_data[k]));
      end
      check("frame_ready", 32'(frame_ready), 32'(exp_fr[k]));
      check("busy", 32'(busy), 32'(exp_busy[k]));
      check("err_overrun", 32'(err_overrun), 32'(exp_err[k]));
      check("short_frame", 32'(short_frame), 32'(exp_short[k]));
      if (rst_chk[k]) begin
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      end
    end
    pixel_done = p;
    frame_done = f;
    rgb_data   = rgb;
    reset      = r;
    model(p, f, rgb, r);
    @(posedge clk);
    k++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 24'h0, 0);
  endtask

  initial begin
    reset = 1'b1; pixel_done = 1'b0; frame_done = 1'b0; rgb_data = '0;
    for (int i = 0; i < 3; i++) step(0, 0, 24'h0, 1);
    idle(2);
    // full frame with primaries and white
    step(1, 0, 24'hFF0000, 0);
    step(1, 0, 24'h00FF00, 0);
    step(1, 0, 24'h0000FF, 0);
    step(0, 1, 24'hFFFFFF, 0);
    idle(6);
    // empty frame
    step(0, 1, 24'h123456, 0);
    idle(6);
    // short frame, then the next frame restarts at address 0
    step(1, 0, 24'h102030, 0);
    step(1, 0, 24'h405060, 0);
    step(0, 1, 24'h708090, 0);
    idle(6);
    step(1, 0, 24'hA0B0C0, 0);
    step(0, 1, 24'h000000, 0);
    idle(6);
    // overrun: extra pixel dropped, frame_done pixel written last
    step(1, 0, 24'h111111, 0);
    step(1, 0, 24'h222222, 0);
    step(1, 0, 24'h333333, 0);
    step(1, 0, 24'h444444, 0);
    step(0, 1, 24'h555555, 0);
    idle(6);
    step(1, 0, 24'h010203, 0);
    step(0, 1, 24'h040506, 0);
    idle(6);
    // reset mid-frame
    step(1, 0, 24'hABCDEF, 0);
    step(1, 0, 24'hFEDCBA, 0);
    step(0, 0, 24'h0, 1);
    idle(4);
    step(1, 0, 24'h0F0F0F, 0);
    step(1, 0, 24'hF0F0F0, 0);
    step(1, 0, 24'h00FFFF, 0);
    step(0, 1, 24'hFFFF00, 0);
    idle(6);
    // strobe during flush
    step(1, 0, 24'h808080, 0);
    step(0, 1, 24'h7F7F7F, 0);
    step(1, 0, 24'h606060, 0);
    idle(6);
    // simultaneous strobes
    step(1, 0, 24'h11AA22, 0);
    step(1, 0, 24'h33BB44, 0);
    step(1, 0, 24'h55CC66, 0);
    step(1, 1, 24'h77DD88, 0);
    idle(6);
    for (int i = 0; i < 2000; i++) begin
      bit p, f, r;
      p = ($urandom_range(0, 99) < 45);
      f = ($urandom_range(0, 99) < 10);
      r = ($urandom_range(0, 999) < 8);
      if (r) step(0, 0, 24'h0, 1);
      else   step(p, f, 24'($urandom), 0);
    end
    idle(8);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
